// File: rtl/legv8_control_unit.sv
// LEGv8 multicycle control unit: sequences one instruction at a time
// through decode/execute/memory/writeback and drives the datapath control word.
module legv8_control_unit #(
  parameter int K_WIDTH = 64
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [31:0]        INSTR,
  input  logic               INSTR_VALID,
  output logic               INSTR_READY,
  input  logic [3:0]         STAT,
  output logic [4:0]         SA,
  output logic [4:0]         SB,
  output logic [4:0]         DA,
  output logic               WR,
  output logic [4:0]         FS,
  output logic               C0,
  output logic [K_WIDTH-1:0] K,
  output logic               M,
  output logic               EN_ALU,
  output logic               EN_ADDR_ALU,
  output logic               EN_B,
  output logic               RCS,
  output logic               RWE,
  output logic               ROE,
  output logic [3:0]         FLAGS,
  output logic               DONE,
  output logic               ILLEGAL
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_LD_ADDR,
    S_LD_WB,
    S_ST
  } state_t;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_ORR,
    OP_EOR,
    OP_ADDS,
    OP_SUBS,
    OP_ADDI,
    OP_SUBI,
    OP_LDUR,
    OP_STUR
  } op_t;

  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_EOR = 5'b01100;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;
  op_t         op;

  logic [10:0]        opc11;
  logic [9:0]         opc10;
  logic [4:0]         rd, rn, rm;
  logic [K_WIDTH-1:0] alu_imm, dt_addr;
  logic               is_itype, is_rtype, sets_flags;
  logic [4:0]         op_fs;
  logic               op_c0;

  assign opc11   = ir_q[31:21];
  assign opc10   = ir_q[31:22];
  assign rd      = ir_q[4:0];
  assign rn      = ir_q[9:5];
  assign rm      = ir_q[20:16];
  assign alu_imm = {{(K_WIDTH-12){1'b0}}, ir_q[21:10]};
  assign dt_addr = {{(K_WIDTH-9){ir_q[20]}}, ir_q[20:12]};

  always_comb begin
    unique case (1'b1)
      (opc11 == 11'b10001011000): op = OP_ADD;
      (opc11 == 11'b11001011000): op = OP_SUB;
      (opc11 == 11'b10001010000): op = OP_AND;
      (opc11 == 11'b10101010000): op = OP_ORR;
      (opc11 == 11'b11001010000): op = OP_EOR;
      (opc11 == 11'b10101011000): op = OP_ADDS;
      (opc11 == 11'b11101011000): op = OP_SUBS;
      (opc10 == 10'b1001000100):  op = OP_ADDI;
      (opc10 == 10'b1101000100):  op = OP_SUBI;
      (opc11 == 11'b11111000010): op = OP_LDUR;
      (opc11 == 11'b11111000000): op = OP_STUR;
      default:                    op = OP_NONE;
    endcase
  end

  assign is_itype   = (op == OP_ADDI) || (op == OP_SUBI);
  assign is_rtype   = (op == OP_ADD)  || (op == OP_SUB)  ||
                      (op == OP_AND)  || (op == OP_ORR)  ||
                      (op == OP_EOR)  || (op == OP_ADDS) ||
                      (op == OP_SUBS);
  assign sets_flags = (op == OP_ADDS) || (op == OP_SUBS);

  always_comb begin
    op_fs = FS_ADD;
    op_c0 = 1'b0;
    unique case (op)
      OP_SUB, OP_SUBS, OP_SUBI: begin
        op_fs = FS_SUB;
        op_c0 = 1'b1;
      end
      OP_AND:  op_fs = FS_AND;
      OP_ORR:  op_fs = FS_ORR;
      OP_EOR:  op_fs = FS_EOR;
      default: op_fs = FS_ADD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    unique case (state_q)
      S_IDLE: begin
        if (INSTR_VALID) begin
          ir_d    = INSTR;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_rtype || is_itype) state_d = S_EXEC;
        else if (op == OP_LDUR)   state_d = S_LD_ADDR;
        else if (op == OP_STUR)   state_d = S_ST;
        else                      state_d = S_IDLE;
      end
      S_EXEC: begin
        if (sets_flags) flags_d = STAT;
        state_d = S_IDLE;
      end
      S_LD_ADDR: state_d = S_LD_WB;
      S_LD_WB:   state_d = S_IDLE;
      S_ST:      state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  // Moore decode: reset forces S_IDLE, so every enable drops with RST.
  always_comb begin
    INSTR_READY = 1'b0;
    SA          = '0;
    SB          = '0;
    DA          = '0;
    WR          = 1'b0;
    FS          = '0;
    C0          = 1'b0;
    K           = '0;
    M           = 1'b0;
    EN_ALU      = 1'b0;
    EN_ADDR_ALU = 1'b0;
    EN_B        = 1'b0;
    RCS         = 1'b0;
    RWE         = 1'b0;
    ROE         = 1'b0;
    DONE        = 1'b0;
    ILLEGAL     = 1'b0;
    unique case (state_q)
      S_IDLE:   INSTR_READY = 1'b1;
      S_DECODE: ILLEGAL = (op == OP_NONE);
      S_EXEC: begin
        SA     = rn;
        SB     = rm;
        DA     = rd;
        FS     = op_fs;
        C0     = op_c0;
        EN_ALU = 1'b1;
        WR     = 1'b1;
        DONE   = 1'b1;
        if (is_itype) begin
          M = 1'b1;
          K = alu_imm;
        end
      end
      S_LD_ADDR, S_LD_WB: begin
        SA          = rn;
        M           = 1'b1;
        K           = dt_addr;
        FS          = FS_ADD;
        EN_ADDR_ALU = 1'b1;
        RCS         = 1'b1;
        ROE         = 1'b1;
        if (state_q == S_LD_WB) begin
          DA   = rd;
          WR   = 1'b1;
          DONE = 1'b1;
        end
      end
      S_ST: begin
        SA          = rn;
        SB          = rd;
        M           = 1'b1;
        K           = dt_addr;
        FS          = FS_ADD;
        EN_ADDR_ALU = 1'b1;
        EN_B        = 1'b1;
        RCS         = 1'b1;
        RWE         = 1'b1;
        DONE        = 1'b1;
      end
      default: INSTR_READY = 1'b0;
    endcase
  end

  assign FLAGS = flags_q;

endmodule

// File: doc/legv8_control_unit.md
Name: legv8_control_unit

Overview:
- Multicycle sequencer that drives the control word of the LEGv8 datapath (register file, ALU, K mux, bus tri-states, single-port RAM) and consumes its 4-bit status.
- Accepts one 32-bit instruction at a time over a valid/ready handshake, decodes a LEGv8 subset, and steps the datapath through execute, memory and writeback states.
- Latches condition flags from flag-setting instructions.

Parameters:
- K_WIDTH, 64, width of the constant output K.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- INSTR  input  32  instruction word.
- INSTR_VALID  input  1  INSTR is valid this cycle.
- INSTR_READY  output  1  unit can accept an instruction.
- STAT  input  4  ALU status {V,C,N,Z}, bit 3 = V, bit 0 = Z.
- SA  output  5  A-bus register select.
- SB  output  5  B-bus register select.
- DA  output  5  destination register select.
- WR  output  1  register-file write enable.
- FS  output  5  ALU function select.
- C0  output  1  ALU carry-in.
- K  output  K_WIDTH  constant to datapath.
- M  output  1  mux select; 1 = K, 0 = B-bus.
- EN_ALU  output  1  ALU result onto DBUS.
- EN_ADDR_ALU  output  1  ALU result onto RAM address bus.
- EN_B  output  1  B-bus onto DBUS.
- RCS, RWE, ROE  output  1 each  RAM chip select / write / output enable, active-high.
- FLAGS  output  4  latched {V,C,N,Z}.
- DONE  output  1  one-cycle pulse when an instruction retires.
- ILLEGAL  output  1  one-cycle pulse on an undecodable instruction.

Behaviour:
- Reset (RST=0, asynchronous):
  - State = IDLE; IR = 0; FLAGS = 0.
  - All control outputs = 0, including DONE and ILLEGAL; INSTR_READY = 1.
  - Reset mid-operation aborts immediately. No WR, RWE or tri-state enable may remain asserted after RST falls.
- Control outputs are a Moore decode of state and IR. Any output not listed for a state is 0.
- Field extraction:
  - Rd/Rt = IR[4:0], Rn = IR[9:5], Rm = IR[20:16].
  - ALU_imm = IR[21:10], zero-extended to K_WIDTH.
  - DT_addr = IR[20:12], sign-extended to K_WIDTH.
- Opcodes:
  - R-type, IR[31:21]: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, EOR 11001010000, ADDS 10101011000, SUBS 11101011000.
  - I-type, IR[31:22]: ADDI 1001000100, SUBI 1101000100.
  - D-type, IR[31:21]: LDUR 11111000010, STUR 11111000000.
- FS/C0 encoding:
  - ADD: 01000 / 0.
  - SUB: 01001 / 1.
  - AND: 00000 / 0.
  - ORR: 00100 / 0.
  - EOR: 01100 / 0.
- States and transitions:
  - IDLE: INSTR_READY=1. If INSTR_VALID, IR <= INSTR and go to DECODE. INSTR is ignored when INSTR_READY=0.
  - DECODE: no enables asserted.
    - Undecodable opcode: ILLEGAL=1, go to IDLE.
    - R/I-type: go to EXEC.
    - LDUR: go to LD_ADDR.
    - STUR: go to ST.
  - EXEC: SA=Rn, SB=Rm, DA=Rd, FS/C0 per op, EN_ALU=1, WR=1, DONE=1.
    - M=0 for R-type; M=1 with K=ALU_imm for I-type.
    - ADDS/SUBS: FLAGS <= STAT on the exiting edge.
    - Go to IDLE.
  - LD_ADDR: SA=Rn, M=1, K=DT_addr, FS=ADD, EN_ADDR_ALU=1, RCS=1, ROE=1. Go to LD_WB.
  - LD_WB: same signals as LD_ADDR, plus DA=Rt, WR=1, DONE=1. EN_ALU=0 so the RAM drives DBUS. Go to IDLE.
  - ST: SA=Rn, SB=Rt, M=1, K=DT_addr, FS=ADD, EN_ADDR_ALU=1, EN_B=1, RCS=1, RWE=1, DONE=1. Go to IDLE.
- Invariants:
  - At most one of EN_ALU and EN_B is 1 in any state, and neither is 1 while ROE=1.
  - RWE and ROE are never both 1.
- Latency from handshake edge to retire:
  - R/I-type: 2 cycles, writeback on the EXEC exit edge.
  - STUR: 2 cycles.
  - LDUR: 3 cycles.
  - INSTR_READY returns 1 the cycle after DONE or ILLEGAL.
- Only ADDS/SUBS in EXEC update FLAGS; all other instructions hold FLAGS.
- Register 31 receives no special treatment; the datapath handles XZR.

Test Plan:
1. Reset held low with INSTR_VALID=1 -> INSTR_READY=1, all control outputs 0, FLAGS=0, no state advance. Assert RST in LD_WB -> WR, RCS, ROE drop to 0 before the next CLK edge; state is IDLE.
2. ADD X3,X1,X2 (0x8B020023) -> DECODE then EXEC. EXEC shows SA=1, SB=2, DA=3, FS=01000, C0=0, M=0, EN_ALU=1, WR=1, DONE=1. INSTR_READY=1 two cycles after acceptance.
3. SUBS X0,X1,X2 with STAT driven 4'b0101 in EXEC -> FLAGS=0101 after EXEC. A following ADD with STAT=1111 leaves FLAGS=0101.
4. ADDI X5,X4,#4095 -> EXEC with M=1, K=64'h0000_0000_0000_0FFF, FS=01000, DA=5, WR=1.
5. LDUR X7,[X2,#-8] -> LD_ADDR then LD_WB. K=64'hFFFF_FFFF_FFFF_FFF8, EN_ADDR_ALU=1, RCS=ROE=1 in both states. WR=1 with DA=7 only in LD_WB. EN_ALU=0 throughout. STUR X7,[X2,#16] -> ST with SB=7, EN_B=1, RWE=1, K=16, one cycle, DONE=1.
6. INSTR=0x00000000 -> ILLEGAL pulse in DECODE, no WR/RWE, back to IDLE. INSTR_VALID toggled while busy -> ignored; IR unchanged.
